uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, is the clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, is the serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (434 at defaults).
REQ-003 Parameter FIFO_DEPTH, default 4, is the receive buffer depth in bytes and SHALL be a power of two.
REQ-004 Port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port rxd  input  1  serial line, asynchronous to clk, idles high.
REQ-007 Port rx_data  output  8  byte at the head of the FIFO.
REQ-008 Port rx_valid  output  1  high while the FIFO is not empty.
REQ-009 Port rx_ready  input  1  consumer accept; a byte is popped on a cycle where rx_valid and rx_ready are both high.
REQ-010 Port frame_err  output  1  one-cycle pulse when a received stop bit samples low.
REQ-011 Port overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 Port busy  output  1  high whenever the frame FSM is not in IDLE.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer before use; all rxd timing below refers to the synchronized signal.
REQ-014 Frame format SHALL be 8N1: one start bit, 8 data bits sent LSB first, one stop bit.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on a high-to-low transition of the synchronized rxd; a line held low (break) SHALL NOT retrigger.
REQ-017 START SHALL count CLKS_PER_BIT/2 clocks and then sample: low -> DATA, high -> IDLE (glitch rejected, no outputs).
REQ-018 DATA SHALL sample every CLKS_PER_BIT clocks from the mid-start point, shifting 8 bits LSB first, then go to STOP.
REQ-019 STOP SHALL sample once after a further CLKS_PER_BIT clocks, then return to IDLE on the next cycle.
REQ-020 A stop sample of 1 SHALL push the byte into the FIFO; a stop sample of 0 SHALL pulse frame_err and discard the byte.
REQ-021 rx_valid SHALL rise on the cycle after the push; end-to-end latency is 2 sync cycles + CLKS_PER_BIT*9 + CLKS_PER_BIT/2 + 1.
REQ-022 FIFO full with no pop: the new byte is dropped, overrun pulses, and FIFO contents are unchanged.
REQ-023 FIFO full with a pop in the same cycle as the push: both occur, the count is unchanged, and overrun stays low.
REQ-024 Push into an empty FIFO SHALL NOT be visible on rx_data in the same cycle; there is no bypass path.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits.
REQ-026 rx_data SHALL hold its value while rx_valid is high and rx_ready is low.

Reset
REQ-027 Reset SHALL immediately force rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, FIFO empty, bit counters 0, and synchronizer flops=1.
REQ-028 Reset asserted mid-frame SHALL abandon the partial byte; after release, reception SHALL resume on the next falling edge.

Structure
REQ-029 The FSM state encodings and the CLKS_PER_BIT derivation SHALL live in shared package uart_pkg, for reuse by a future uart_tx.
REQ-030 The FIFO SHALL be a separate sub-module, uart_rx_fifo (push, pop, data in/out, full, empty).

Verification (CLK_FREQ=50000000, BAUD=115200)
REQ-031 Send 0xA5 with rx_ready=1 -> exactly one rx_valid cycle with rx_data=0xA5, at the latency in REQ-021; frame_err=0.
REQ-032 Pulse rxd low for 100 clocks -> busy returns to 0 after the START sample, with no rx_valid and no frame_err.
REQ-033 Send 0x55 with the stop bit driven low -> one frame_err pulse, no rx_valid, and the FSM does not restart until rxd goes high then low.
REQ-034 With rx_ready=0, send 0x01..0x05 -> overrun pulses on 0x05; then set rx_ready=1 -> reads 0x01, 0x02, 0x03, 0x04, then rx_valid=0.
REQ-035 Assert reset during data bit 3 of 0x3C, release, then resend 0x3C -> all outputs go to 0 at once, then 0x3C is received correctly.
REQ-036 Send 0x00 then 0xFF back-to-back with no idle gap -> both bytes are received in order, with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state encoding and baud divisor.
// Used by uart_rx today and by a future uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  function automatic int unsigned clks_per_bit(
    input int unsigned clk_freq,
    input int unsigned baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO, DEPTH a power of two; no write-to-read bypass.
// Ports: clk, reset, push/din, pop/dout, full, empty.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // a pop frees the slot a push into a full FIFO needs
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count
             + (AW+1)'(do_push)
             - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with synchronizer, mid-bit sampling and byte FIFO.
// Ports: clk, reset, rxd in; rx_data/rx_valid/rx_ready stream out; frame_err, overrun, busy.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CPB  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HALF = CPB / 2;
  localparam int          CW   = $clog2(CPB + 1);

  rx_state_t     state;
  rx_state_t     state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          push;
  logic          ferr_n;

  logic sync_q1;
  logic rxd_s;
  logic rxd_d;
  logic fall;

  logic fifo_full;
  logic fifo_empty;
  logic pop;

  // edge detect on the synchronized line so a held-low break never retriggers
  assign fall = rxd_d & ~rxd_s;
  assign busy = (state != IDLE);

  assign rx_valid = ~fifo_empty;
  assign pop      = rx_valid & rx_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_idx;
    shreg_n = shreg;
    push    = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (fall) state_n = START;
      end
      START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_n   = '0;
          shreg_n = {rxd_s, shreg[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_n   = '0;
          state_n = IDLE;
          push    = rxd_s;
          ferr_n  = ~rxd_s;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1   <= 1'b1;
      rxd_s     <= 1'b1;
      rxd_d     <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync_q1   <= rxd;
      rxd_s     <= sync_q1;
      rxd_d     <= rxd_s;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shreg     <= shreg_n;
      frame_err <= ferr_n;
      overrun   <= push & fifo_full & ~pop;
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (shreg),
    .dout (rx_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 115200 baud.
// Drives serial frames and checks outputs with immediate assertions.
module tb_uart_rx;

  localparam int CPB = 434;
  localparam int LAT = 2 + CPB * 9 + CPB / 2 + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;

  int vcnt = 0;
  int fcnt = 0;
  int ocnt = 0;
  int got_n = 0;
  int first_valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got [256];

  int v0, f0, o0, g0;
  logic [7:0] b;

  uart_rx dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      got[got_n[7:0]] = rx_data;
      got_n = got_n + 1;
      vcnt  = vcnt + 1;
    end
    if (rx_valid && !prev_valid) first_valid_cyc = cyc;
    prev_valid = rx_valid;
    if (frame_err) fcnt = fcnt + 1;
    if (overrun)   ocnt = ocnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // caller is positioned #1 after a rising edge; returns the same way
  task automatic send(input logic [7:0] d, input logic stop_bit);
    t_start = cyc;
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    idle(3);
    chk("rst_data",  int'(rx_data),   0);
    chk("rst_valid", int'(rx_valid),  0);
    chk("rst_ferr",  int'(frame_err), 0);
    chk("rst_ovr",   int'(overrun),   0);
    chk("rst_busy",  int'(busy),      0);
    reset = 1'b0;
    idle(5);

    v0 = vcnt; f0 = fcnt; g0 = got_n;
    send(8'hA5, 1'b1);
    idle(20);
    chk("a5_count", vcnt - v0, 1);
    chk("a5_data",  int'(got[g0[7:0]]), 'hA5);
    chk("a5_lat",   first_valid_cyc - t_start, LAT);
    chk("a5_ferr",  fcnt - f0, 0);

    v0 = vcnt; f0 = fcnt;
    t_start = cyc;
    rxd = 1'b0;
    idle(100);
    rxd = 1'b1;
    repeat (119) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_hi", int'(busy), 1);
    @(negedge clk);
    chk("glitch_busy_lo", int'(busy), 0);
    idle(300);
    chk("glitch_valid", vcnt - v0, 0);
    chk("glitch_ferr",  fcnt - f0, 0);

    v0 = vcnt; f0 = fcnt;
    send(8'h55, 1'b0);
    idle(2 * CPB);
    chk("ferr_count", fcnt - f0, 1);
    chk("ferr_valid", vcnt - v0, 0);
    chk("ferr_break", int'(busy), 0);
    rxd = 1'b1;
    idle(20);
    chk("ferr_idle",  int'(busy), 0);

    rx_ready = 1'b0;
    v0 = vcnt; o0 = ocnt; g0 = got_n;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    idle(10);
    chk("ovr_none", ocnt - o0, 0);
    chk("ovr_valid", int'(rx_valid), 1);
    chk("ovr_head", int'(rx_data), 1);
    send(8'h05, 1'b1);
    idle(10);
    chk("ovr_pulse", ocnt - o0, 1);
    chk("ovr_hold", int'(rx_data), 1);
    rx_ready = 1'b1;
    idle(10);
    chk("ovr_reads", vcnt - v0, 4);
    for (int i = 0; i < 4; i++)
      chk("ovr_byte", int'(got[8'(g0 + i)]), i + 1);
    chk("ovr_empty", int'(rx_valid), 0);

    rx_ready = 1'b0;
    send(8'h77, 1'b1);
    idle(10);
    chk("pre_valid", int'(rx_valid), 1);
    chk("pre_data",  int'(rx_data), 'h77);
    b = 8'h3C;
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = b[3];
    idle(CPB / 2);
    chk("mid_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("ar_busy",  int'(busy), 0);
    chk("ar_valid", int'(rx_valid), 0);
    chk("ar_data",  int'(rx_data), 0);
    chk("ar_ferr",  int'(frame_err), 0);
    chk("ar_ovr",   int'(overrun), 0);
    rxd = 1'b1;
    idle(5);
    reset = 1'b0;
    rx_ready = 1'b1;
    idle(5);
    v0 = vcnt; f0 = fcnt; g0 = got_n;
    send(8'h3C, 1'b1);
    idle(20);
    chk("re_count", vcnt - v0, 1);
    chk("re_data",  int'(got[g0[7:0]]), 'h3C);
    chk("re_ferr",  fcnt - f0, 0);

    v0 = vcnt; f0 = fcnt; o0 = ocnt; g0 = got_n;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    idle(20);
    chk("b2b_count", vcnt - v0, 2);
    chk("b2b_first", int'(got[g0[7:0]]), 'h00);
    chk("b2b_second", int'(got[8'(g0 + 1)]), 'hFF);
    chk("b2b_ferr", fcnt - f0, 0);
    chk("b2b_ovr",  ocnt - o0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
